// File: rtl/fetch_stage_if.sv
// fetch_stage_if: decode/hazard/CP0/imem signals seen by the fetch stage.
interface fetch_stage_if;
  logic        stall;
  logic        ifExc;
  logic [31:0] epc;
  logic [31:0] pcNext_If;
  logic        ifBranchOrJump_If;
  logic        ifEret_If;
  logic        ifBd_Id;
  logic [31:0] imRd;
  logic [31:0] imAddr;
  logic [31:0] pc_IfId;
  logic [31:0] instr_IfId;
  logic [4:0]  excCode_IfId;
  logic        ifBd_IfId;
  logic        reset_IfId;
  modport master (
    output stall, ifExc, epc, pcNext_If, ifBranchOrJump_If, ifEret_If, ifBd_Id, imRd,
    input  imAddr, pc_IfId, instr_IfId, excCode_IfId, ifBd_IfId, reset_IfId
  );
  modport slave (
    input  stall, ifExc, epc, pcNext_If, ifBranchOrJump_If, ifEret_If, ifBd_Id, imRd,
    output imAddr, pc_IfId, instr_IfId, excCode_IfId, ifBd_IfId, reset_IfId
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, fetch AdEL detection and IfId register.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave f
);
  logic [31:0] pc_q, pc_d, pc_ifid_q, pc_ifid_d, instr_q, instr_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d, rst_ifid_q, adel, hold, bubble;
  always_comb begin
    adel      = pc_q[1:0] != 2'b00 || pc_q < IM_LO || pc_q > IM_HI;
    hold      = f.stall && !f.ifExc;
    bubble    = f.ifExc || (!f.stall && f.ifEret_If);
    pc_d      = f.ifExc ? EXC_ENTRY : hold ? pc_q : f.ifEret_If ? f.epc :
                f.ifBranchOrJump_If ? f.pcNext_If : pc_q + 32'd4;
    // a bubble carries the redirect target so a later interrupt gets the right EPC
    pc_ifid_d = hold ? pc_ifid_q : bubble ? pc_d : pc_q;
    instr_d   = hold ? instr_q : (bubble || adel) ? 32'd0 : f.imRd;
    exc_d     = hold ? exc_q : (!bubble && adel) ? EXC_ADEL : 5'd0;
    bd_d      = hold ? bd_q : !bubble && f.ifBd_Id;
  end
  always_ff @(posedge clk) begin
    rst_ifid_q <= reset;
    if (reset) begin
      pc_q      <= PC_RESET;
      pc_ifid_q <= PC_RESET;
      instr_q   <= 32'd0;
      exc_q     <= 5'd0;
      bd_q      <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_ifid_q <= pc_ifid_d;
      instr_q   <= instr_d;
      exc_q     <= exc_d;
      bd_q      <= bd_d;
    end
  end
  assign f.imAddr       = pc_q;
  assign f.pc_IfId      = pc_ifid_q;
  assign f.instr_IfId   = instr_q;
  assign f.excCode_IfId = exc_q;
  assign f.ifBd_IfId    = bd_q;
  assign f.reset_IfId   = rst_ifid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven vectors through a scoreboard queue, plus a mid-run reset sequence.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  fetch_stage_if f ();
  fetch_stage dut (.clk(clk), .reset(reset), .f(f));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[15:0] ^ 16'hBEEF};
  endfunction
  assign f.imRd = mem(f.imAddr);
  typedef struct {
    logic        rs, st, ex, er, br, bd;
    logic [31:0] epc, nxt;
    logic [31:0] e_ia, e_pc, e_ins;
    logic [4:0]  e_ec;
    logic        e_bd, e_rst;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    reset               = v.rs;
    f.stall             = v.st;
    f.ifExc             = v.ex;
    f.ifEret_If         = v.er;
    f.ifBranchOrJump_If = v.br;
    f.ifBd_Id           = v.bd;
    f.epc               = v.epc;
    f.pcNext_If         = v.nxt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("imAddr[%0d]", idx), f.imAddr, e.e_ia);
    chk($sformatf("pc_IfId[%0d]", idx), f.pc_IfId, e.e_pc);
    chk($sformatf("instr_IfId[%0d]", idx), f.instr_IfId, e.e_ins);
    chk($sformatf("excCode_IfId[%0d]", idx), {27'd0, f.excCode_IfId}, {27'd0, e.e_ec});
    chk($sformatf("ifBd_IfId[%0d]", idx), {31'd0, f.ifBd_IfId}, {31'd0, e.e_bd});
    chk($sformatf("reset_IfId[%0d]", idx), {31'd0, f.reset_IfId}, {31'd0, e.e_rst});
  endtask
  initial begin
    // rs st ex er br bd  epc  nxt  | imAddr pc_IfId instr exc bd rst
    tbl.push_back('{1,0,0,0,0,0, 0, 0, 32'h3000, 32'h3000, 0, 0, 0, 1});
    tbl.push_back('{1,0,0,0,0,0, 0, 0, 32'h3000, 32'h3000, 0, 0, 0, 1});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h3004, 32'h3000, mem(32'h3000), 0, 0, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h3008, 32'h3004, mem(32'h3004), 0, 0, 0});
    tbl.push_back('{0,0,0,0,1,1, 0, 32'h3040, 32'h3040, 32'h3008, mem(32'h3008), 0, 1, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h3044, 32'h3040, mem(32'h3040), 0, 0, 0});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{0,1,0,0,1,1, 0, 32'h3010, 32'h3044, 32'h3040, mem(32'h3040), 0, 0, 0});
    tbl.push_back('{0,0,0,0,1,1, 0, 32'h3010, 32'h3010, 32'h3044, mem(32'h3044), 0, 1, 0});
    tbl.push_back('{0,1,1,0,0,1, 0, 0, 32'h4180, 32'h4180, 0, 0, 0, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h4184, 32'h4180, mem(32'h4180), 0, 0, 0});
    tbl.push_back('{0,0,0,1,1,1, 32'h3024, 32'h3200, 32'h3024, 32'h3024, 0, 0, 0, 0});
    tbl.push_back('{0,0,0,0,1,0, 0, 32'h3002, 32'h3002, 32'h3024, mem(32'h3024), 0, 0, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h3006, 32'h3002, 0, 4, 0, 0});
    tbl.push_back('{0,0,0,0,1,0, 0, 32'h7000, 32'h7000, 32'h3006, 0, 4, 0, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h7004, 32'h7000, 0, 4, 0, 0});
    tbl.push_back('{0,0,0,0,1,0, 0, 32'h6FFC, 32'h6FFC, 32'h7004, 0, 4, 0, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h7000, 32'h6FFC, mem(32'h6FFC), 0, 0, 0});
    tbl.push_back('{0,0,0,0,1,0, 0, 32'h2FFC, 32'h2FFC, 32'h7000, 0, 4, 0, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h3000, 32'h2FFC, 0, 4, 0, 0});
    tbl.push_back('{0,0,0,0,0,0, 0, 0, 32'h3004, 32'h3000, mem(32'h3000), 0, 0, 0});
    tbl.push_back('{0,0,1,1,0,0, 32'h3100, 0, 32'h4180, 32'h4180, 0, 0, 0, 0});
    tbl.push_back('{0,0,0,0,1,0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4180, mem(32'h4180), 0, 0, 0});
    tbl.push_back('{0,0,0,0,0,1, 0, 0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 4, 1, 0});
    tbl.push_back('{0,1,0,1,0,0, 32'h3050, 0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 4, 1, 0});
    reset = 1'b1;
    f.stall = 0; f.ifExc = 0; f.ifEret_If = 0; f.ifBranchOrJump_If = 0;
    f.ifBd_Id = 0; f.epc = 0; f.pcNext_If = 0;
    foreach (tbl[i]) step(tbl[i], i);
    // mid-run reset overrides a pending redirect, then fetch restarts at PC_RESET
    step('{1,0,0,0,1,1, 0, 32'h5000, 32'h3000, 32'h3000, 0, 0, 0, 1}, 100);
    step('{0,0,0,0,0,0, 0, 0, 32'h3004, 32'h3000, mem(32'h3000), 0, 0, 0}, 101);
    step('{0,1,0,0,0,0, 0, 0, 32'h3004, 32'h3000, mem(32'h3000), 0, 0, 0}, 102);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
